// File: rtl/wb_dpbram_pkg.sv
// Shared types and helpers for the Wishbone front-end of the simple dual-port BRAM.
// Holds the controller state encoding, the byte-select width rule and the byte-lane mask expansion.
package wb_dpbram_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_MERGE = 1'b1
   } state_e;

   function automatic int sel_width(input int data_width);
      return data_width / BYTE_W;
   endfunction

   // One select bit becomes a full byte lane of mask bits.
   function automatic logic [BYTE_W-1:0] byte_mask(input logic sel_bit);
      return {BYTE_W{sel_bit}};
   endfunction

endpackage

// File: rtl/wb_byte_merge.sv
// Byte-lane merge for read-modify-write: selected lanes come from the new word,
// the rest keep the value read back from the BRAM.
module wb_byte_merge
   import wb_dpbram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int SEL_WIDTH  = sel_width(DATA_WIDTH)
) (
   input  logic [DATA_WIDTH-1:0] i_old,
   input  logic [DATA_WIDTH-1:0] i_new,
   input  logic [SEL_WIDTH-1:0]  i_sel,
   output logic [DATA_WIDTH-1:0] o_merged
);

   logic [DATA_WIDTH-1:0] mask;

   for (genvar b = 0; b < SEL_WIDTH; b++) begin : g_lane
      assign mask[BYTE_W*b +: BYTE_W] = byte_mask(i_sel[b]);
   end

   assign o_merged = (i_new & mask) | (i_old & ~mask);

endmodule

// File: rtl/wb_dpbram_ctrl.sv
// Wishbone B4 pipelined slave in front of a simple dual-port BRAM (A = write, B = registered read).
// Full-word writes and reads take one cycle; byte-select writes run as a one-cycle-stalled RMW.
module wb_dpbram_ctrl
   import wb_dpbram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int SEL_WIDTH  = sel_width(DATA_WIDTH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wb_cyc,
   input  logic                  i_wb_stb,
   input  logic                  i_wb_we,
   input  logic [ADDR_WIDTH-1:0] i_wb_addr,
   input  logic [DATA_WIDTH-1:0] i_wb_data,
   input  logic [SEL_WIDTH-1:0]  i_wb_sel,
   output logic                  o_wb_stall,
   output logic                  o_wb_ack,
   output logic [DATA_WIDTH-1:0] o_wb_data,
   output logic                  o_enA,
   output logic                  o_weA,
   output logic [ADDR_WIDTH-1:0] o_addrA,
   output logic [DATA_WIDTH-1:0] o_dinA,
   output logic                  o_enB,
   output logic [ADDR_WIDTH-1:0] o_addrB,
   input  logic [DATA_WIDTH-1:0] i_doutB
);

   state_e                state_q, state_d;
   logic                  ack_q, ack_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [SEL_WIDTH-1:0]  sel_q, sel_d;
   logic                  accept;
   logic                  sel_full;
   logic                  sel_none;
   logic [DATA_WIDTH-1:0] merged;

   assign o_wb_stall = (state_q == ST_MERGE);
   assign accept     = i_rst_n & i_wb_cyc & i_wb_stb & ~o_wb_stall;
   assign sel_full   = &i_wb_sel;
   assign sel_none   = ~|i_wb_sel;
   assign o_wb_ack   = ack_q;
   assign o_wb_data  = i_doutB;

   // Port B data arriving in MERGE is the old word read during the accept cycle.
   wb_byte_merge #(
      .DATA_WIDTH (DATA_WIDTH),
      .SEL_WIDTH  (SEL_WIDTH)
   ) u_merge (
      .i_old    (i_doutB),
      .i_new    (data_q),
      .i_sel    (sel_q),
      .o_merged (merged)
   );

   always_comb begin
      // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      ack_d   = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      sel_d   = sel_q;
      o_enA   = 1'b0;
      o_weA   = 1'b0;
      o_addrA = i_wb_addr;
      o_dinA  = i_wb_data;
      o_enB   = 1'b0;
      o_addrB = i_wb_addr;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!i_wb_we) begin
                  o_enB = 1'b1;
                  ack_d = 1'b1;
               end else if (sel_full) begin
                  o_enA = 1'b1;
                  o_weA = 1'b1;
                  ack_d = 1'b1;
               end else if (sel_none) begin
                  ack_d = 1'b1;
               end else begin
                  o_enB   = 1'b1;
                  addr_d  = i_wb_addr;
                  data_d  = i_wb_data;
                  sel_d   = i_wb_sel;
                  state_d = ST_MERGE;
               end
            end
         end
         ST_MERGE: begin
            o_enA   = 1'b1;
            o_weA   = 1'b1;
            o_addrA = addr_q;
            o_dinA  = merged;
            ack_d   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A dropped cycle kills the ack but lets an in-flight merge finish, keeping memory consistent.
      if (!i_wb_cyc) ack_d = 1'b0;

      if (!i_rst_n) begin
         o_enA = 1'b0;
         o_weA = 1'b0;
         o_enB = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         ack_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         sel_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         ack_q   <= ack_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
      end
   end

endmodule

// File: doc/wb_dpbram_ctrl.md
Name: wb_dpbram_ctrl

Overview:
- Wishbone B4 pipelined slave front-end that drives the simple dual-port BRAM.
- Port A of the BRAM is write-only; port B is read-only with a one-cycle registered read.
- Full-word writes and all reads complete in a single cycle.
- Byte-select partial writes need the BRAM's lack of byte enables hidden, so they run as a stalled read-modify-write (RMW): read on port B, merge, write on port A.
- Sits between the bus interconnect and the BRAM instance.

Parameters:
- DATA_WIDTH, 32, bus and BRAM word width; must be a multiple of 8.
- ADDR_WIDTH, 10, word address width; BRAM depth is 2**ADDR_WIDTH.
- SEL_WIDTH, DATA_WIDTH/8, number of byte-select bits (derived, not to be overridden).

Ports:
- i_clk  in  1  single clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_wb_cyc  in  1  bus cycle.
- i_wb_stb  in  1  request strobe.
- i_wb_we  in  1  1 = write.
- i_wb_addr  in  ADDR_WIDTH  word address.
- i_wb_data  in  DATA_WIDTH  write data.
- i_wb_sel  in  SEL_WIDTH  byte selects.
- o_wb_stall  out  1  request not accepted this cycle.
- o_wb_ack  out  1  request complete.
- o_wb_data  out  DATA_WIDTH  read data, valid when o_wb_ack follows a read.
- o_enA  out  1  BRAM port A enable.
- o_weA  out  1  BRAM port A write enable.
- o_addrA  out  ADDR_WIDTH  BRAM port A address.
- o_dinA  out  DATA_WIDTH  BRAM port A write data.
- o_enB  out  1  BRAM port B enable.
- o_addrB  out  ADDR_WIDTH  BRAM port B address.
- i_doutB  in  DATA_WIDTH  BRAM port B registered read data.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset state: state = IDLE, o_wb_ack = 0, latched addr/data/sel = 0.
- While i_rst_n = 0, all BRAM enables are forced to 0 and o_wb_stall = 0.
- Accept condition: accept = i_rst_n & i_wb_cyc & i_wb_stb & ~o_wb_stall.
- Stall: o_wb_stall = (state == MERGE), combinational.
- FSM has two states, IDLE and MERGE.
- IDLE, accepted read:
  - o_enB = 1 and o_addrB = i_wb_addr, both combinational.
  - o_wb_ack = 1 in the next cycle.
  - o_wb_data = i_doutB, combinational pass-through. Read latency is 1 cycle.
- IDLE, accepted write with sel all ones:
  - o_enA = o_weA = 1, o_addrA = i_wb_addr, o_dinA = i_wb_data, all combinational.
  - o_wb_ack = 1 in the next cycle.
- IDLE, accepted write with sel == 0: no BRAM access; o_wb_ack = 1 in the next cycle.
- IDLE, accepted write with partial sel:
  - Issue a port B read of i_wb_addr.
  - Latch addr, data and sel; go to MERGE.
- MERGE (exactly 1 cycle):
  - o_enA = o_weA = 1, o_addrA = latched addr.
  - o_dinA per byte b: latched_sel[b] ? latched_data byte b : i_doutB byte b.
  - Return to IDLE at the next edge; o_wb_ack = 1 in the cycle after MERGE.
  - Partial write totals: latency 2 cycles, stall high for 1 cycle.
- Ack gating: o_wb_ack is registered and cleared whenever i_wb_cyc = 0. With i_wb_cyc = 0, ack never asserts.
- i_wb_cyc dropped during MERGE: the write still completes (memory stays consistent); its ack is suppressed.
- Back-to-back requests:
  - One request per cycle, so no same-edge port A/B conflict.
  - A read issued in the cycle after a write to the same address returns the new data.
- Reset mid-RMW: MERGE is abandoned, no port A write occurs, and memory keeps its old value.
- o_wb_data during a write ack is don't-care (it equals i_doutB).
- Address wrap is inherent to the ADDR_WIDTH modulo; there is no error/err output.

Decomposition:
- Package wb_dpbram_pkg holds:
  - FSM state encoding (IDLE = 0, MERGE = 1).
  - SEL_WIDTH derivation.
  - A function expanding sel into a byte mask.
- One natural combinational sub-module: wb_byte_merge, with inputs old word, new word and sel, and output the merged word.
- A top-level wrapper instantiates this block plus the BRAM; the wrapper is tested in the integration bench only.

Test Plan:
- Reset: hold i_rst_n = 0 with stb high -> no BRAM enables, ack = 0, stall = 0.
- Full write then read: write 0xDEADBEEF to addr 0x005 (sel 0xF), then read 0x005 in the next cycle -> acks in consecutive cycles; read data 0xDEADBEEF.
- Partial write: addr 0x005 holds 0xDEADBEEF; write 0x11223344 with sel 0x5 -> stall 1 cycle; ack 2 cycles after accept; subsequent read returns 0xDE22BE44.
- Pipelined reads: 4 reads of addrs 0..3 on consecutive cycles, memory pre-loaded with 0xA0..0xA3 -> 4 consecutive acks returning 0xA0, 0xA1, 0xA2, 0xA3.
- sel = 0 write to addr 0x007 holding 0x12345678 -> ack next cycle; subsequent read returns 0x12345678.
- Abort and reset:
  - Partial write accepted, then i_wb_cyc dropped in MERGE -> no ack, but the memory merge is applied.
  - Repeat with i_rst_n pulsed low in MERGE -> no write; state returns to IDLE.
